// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU.
// Op encodings, FSM states and width helpers.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_XOR = 3'd3,
    OP_SLL = 3'd4,
    OP_SRL = 3'd5,
    OP_COM = 3'd6,
    OP_MUL = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } state_e;

  function automatic int shw(input int dsize);
    return $clog2(dsize);
  endfunction

endpackage

// File: rtl/alu_mc_seq_mul.sv
// Iterative shift-add multiplier, one multiplier bit per cycle.
// Returns the full unsigned double-width product.
module seq_mul
  import alu_pkg::*;
#(
  parameter int DSIZE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [DSIZE-1:0]     a,
  input  logic [DSIZE-1:0]     b,
  output logic                 done,
  output logic [2*DSIZE-1:0]   prod
);

  localparam int CW = shw(DSIZE) + 1;

  logic [DSIZE-1:0]   mcand_q, mcand_d;
  logic [2*DSIZE-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               run_q, run_d;
  logic               done_q, done_d;
  logic [DSIZE:0]     psum;

  always_comb begin
    mcand_d = mcand_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    done_d  = 1'b0;
    psum    = {1'b0, acc_q[2*DSIZE-1:DSIZE]}
            + ({1'b0, mcand_q} & {(DSIZE+1){acc_q[0]}});
    if (start) begin
      // first partial product is folded into the start cycle
      mcand_d = a;
      acc_d   = {1'b0, a & {DSIZE{b[0]}}, b[DSIZE-1:1]};
      cnt_d   = '0;
      run_d   = 1'b1;
    end else if (run_q) begin
      acc_d = {psum, acc_q[DSIZE-1:1]};
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(DSIZE - 2)) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      done_q  <= done_d;
    end
  end

  assign done = done_q;
  assign prod = acc_q;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle EX-stage ALU with valid/ready handshakes,
// full flag set and an iterative double-width multiplier.
module alu_mc
  import alu_pkg::*;
#(
  parameter int DSIZE      = 16,
  parameter int SIGNED_CMP = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DSIZE-1:0] a,
  input  logic [DSIZE-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DSIZE-1:0] out,
  output logic [DSIZE-1:0] out_hi,
  output logic             zero,
  output logic             carry,
  output logic             ovf,
  output logic             neg,
  output logic             busy
);

  localparam logic [DSIZE-1:0] DSZ = DSIZE'(DSIZE);

  state_e             state_q, state_d;
  logic [DSIZE-1:0]   out_q, out_d, hi_q, hi_d;
  logic               zero_q, zero_d, carry_q, carry_d;
  logic               ovf_q, ovf_d, neg_q, neg_d;

  logic               accept, mul_start, mul_done;
  logic [2*DSIZE-1:0] prod;
  logic [DSIZE:0]     sum, diff;
  logic [DSIZE-1:0]   res;
  logic               res_c, res_v, le;

  assign in_ready  = (state_q == S_IDLE)
                   || (state_q == S_DONE && out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (op == OP_MUL);

  seq_mul #(.DSIZE(DSIZE)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mul_start),
    .a     (a),
    .b     (b),
    .done  (mul_done),
    .prod  (prod)
  );

  always_comb begin
    sum   = {1'b0, a} + {1'b0, b};
    diff  = {1'b0, a} - {1'b0, b};
    le    = (SIGNED_CMP != 0) ? ($signed(a) <= $signed(b))
                              : (a <= b);
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    unique case (op)
      OP_ADD: begin
        res   = sum[DSIZE-1:0];
        res_c = sum[DSIZE];
        res_v = (a[DSIZE-1] == b[DSIZE-1])
             && (sum[DSIZE-1] != a[DSIZE-1]);
      end
      OP_SUB: begin
        res   = diff[DSIZE-1:0];
        res_c = diff[DSIZE];
        res_v = (a[DSIZE-1] != b[DSIZE-1])
             && (diff[DSIZE-1] != a[DSIZE-1]);
      end
      OP_AND: res = a & b;
      OP_XOR: res = a ^ b;
      OP_SLL: res = (b >= DSZ) ? '0 : a << b;
      OP_SRL: res = (b >= DSZ) ? '0 : a >> b;
      OP_COM: res = {{(DSIZE-1){1'b0}}, le};
      OP_MUL: res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    hi_d    = hi_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    neg_d   = neg_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          if (op == OP_MUL) begin
            state_d = S_MUL;
          end else begin
            state_d = S_DONE;
            out_d   = res;
            hi_d    = '0;
            zero_d  = (res == '0);
            neg_d   = res[DSIZE-1];
            carry_d = res_c;
            ovf_d   = res_v;
          end
        end else if (state_q == S_DONE && out_ready) begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        if (mul_done) begin
          state_d = S_DONE;
          out_d   = prod[DSIZE-1:0];
          hi_d    = prod[2*DSIZE-1:DSIZE];
          zero_d  = (prod == '0);
          neg_d   = prod[2*DSIZE-1];
          carry_d = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      out_q   <= '0;
      hi_q    <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      hi_q    <= hi_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      neg_q   <= neg_d;
    end
  end

  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_MUL);
  assign out       = out_q;
  assign out_hi    = hi_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;
  assign neg       = neg_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed-vector bench for alu_mc at DSIZE=16, unsigned and
// signed-compare instances side by side.
module tb_alu_mc;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready;
  logic [15:0] a, b;
  logic [2:0]  op;

  logic        in_ready, out_valid, zero, carry, ovf, neg, busy;
  logic [15:0] out, out_hi;
  logic        in_ready_s, out_valid_s, zero_s, carry_s;
  logic        ovf_s, neg_s, busy_s;
  logic [15:0] out_s, out_hi_s;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] eo;
    logic [15:0] eos;
    logic [15:0] ehi;
    logic [3:0]  ef;
    int          lat;
  } vec_t;

  vec_t vecs[15];

  alu_mc #(.DSIZE(16), .SIGNED_CMP(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .out_hi(out_hi),
    .zero(zero), .carry(carry), .ovf(ovf), .neg(neg),
    .busy(busy)
  );

  alu_mc #(.DSIZE(16), .SIGNED_CMP(1)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready_s),
    .a(a), .b(b), .op(op),
    .out_valid(out_valid_s), .out_ready(out_ready),
    .out(out_s), .out_hi(out_hi_s),
    .zero(zero_s), .carry(carry_s), .ovf(ovf_s), .neg(neg_s),
    .busy(busy_s)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [15:0] x,
                       input logic [15:0] y);
    @(negedge clk);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_res(input string nm, input logic is_mul,
                          output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      if (is_mul) begin
        chk({nm, " busy"}, busy, 1);
        chk({nm, " in_ready"}, in_ready, 0);
      end
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic consume(input string nm);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk({nm, " consumed"}, out_valid, 0);
  endtask

  initial begin
    int lat;
    string nm;

    vecs[0]  = '{OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 16'h8000, 16'h0000, 4'b0011, 1};
    vecs[1]  = '{OP_SUB, 16'h0003, 16'h0005, 16'hFFFE, 16'hFFFE, 16'h0000, 4'b0101, 1};
    vecs[2]  = '{OP_SUB, 16'h0005, 16'h0005, 16'h0000, 16'h0000, 16'h0000, 4'b1000, 1};
    vecs[3]  = '{OP_MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0001, 16'hFFFE, 4'b0001, 17};
    vecs[4]  = '{OP_SLL, 16'h0001, 16'd20,   16'h0000, 16'h0000, 16'h0000, 4'b1000, 1};
    vecs[5]  = '{OP_SRL, 16'h8000, 16'd15,   16'h0001, 16'h0001, 16'h0000, 4'b0000, 1};
    vecs[6]  = '{OP_COM, 16'hFFFF, 16'h0001, 16'h0000, 16'h0001, 16'h0000, 4'b1000, 1};
    vecs[7]  = '{OP_AND, 16'hF0F0, 16'h3C3C, 16'h3030, 16'h3030, 16'h0000, 4'b0000, 1};
    vecs[8]  = '{OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 4'b1100, 1};
    vecs[9]  = '{OP_MUL, 16'h0003, 16'h0005, 16'h000F, 16'h000F, 16'h0000, 4'b0000, 17};
    vecs[10] = '{OP_MUL, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 4'b1000, 17};
    vecs[11] = '{OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 16'h7FFF, 16'h0000, 4'b0010, 1};
    vecs[12] = '{OP_SRL, 16'hFFFF, 16'd16,   16'h0000, 16'h0000, 16'h0000, 4'b1000, 1};
    vecs[13] = '{OP_COM, 16'h0005, 16'h0005, 16'h0001, 16'h0001, 16'h0000, 4'b0000, 1};
    vecs[14] = '{OP_MUL, 16'h8000, 16'h0002, 16'h0000, 16'h0000, 16'h0001, 4'b0000, 17};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; op = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", in_ready, 1);
    chk("reset out_valid", out_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset out", {out_hi, out}, 0);
    chk("reset flags", {zero, carry, ovf, neg}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      nm = $sformatf("v%0d", i);
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_res(nm, vecs[i].op == OP_MUL, lat);
      chk({nm, " latency"}, lat, vecs[i].lat);
      chk({nm, " out"}, out, vecs[i].eo);
      chk({nm, " out_hi"}, out_hi, vecs[i].ehi);
      chk({nm, " zcvn"}, {zero, carry, ovf, neg}, vecs[i].ef);
      chk({nm, " out signed"}, out_s, vecs[i].eos);
      consume(nm);
    end

    // backpressure: result must hold, inputs ignored
    issue(OP_ADD, 16'h7FFF, 16'h0001);
    wait_res("bp", 1'b0, lat);
    chk("bp latency", lat, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      op = OP_AND; a = 16'h0000; b = 16'h0000; in_valid = 1'b1;
      #1 chk("bp in_ready", in_ready, 0);
      @(posedge clk);
      #1;
      chk("bp out_valid", out_valid, 1);
      chk("bp out", out, 16'h8000);
      chk("bp zcvn", {zero, carry, ovf, neg}, 4'b0011);
    end
    @(negedge clk);
    op = OP_XOR; a = 16'h00FF; b = 16'h0F0F;
    in_valid = 1'b1; out_ready = 1'b1;
    #1 chk("b2b in_ready", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0; out_ready = 1'b0;
    chk("b2b out_valid", out_valid, 1);
    chk("b2b out", out, 16'h0FF0);
    chk("b2b zcvn", {zero, carry, ovf, neg}, 4'b0000);
    consume("b2b");

    // reset during the 8th multiply cycle
    issue(OP_MUL, 16'hFFFF, 16'hFFFF);
    repeat (7) begin
      @(posedge clk);
      #1;
    end
    chk("rst pre busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst busy", busy, 0);
    chk("rst in_ready", in_ready, 1);
    chk("rst out_valid", out_valid, 0);
    chk("rst out", {out_hi, out}, 0);
    chk("rst flags", {zero, carry, ovf, neg}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
    end
    chk("rst abort out_valid", out_valid, 0);
    chk("rst abort busy", busy, 0);
    issue(OP_ADD, 16'h0002, 16'h0003);
    wait_res("post rst", 1'b0, lat);
    chk("post rst latency", lat, 1);
    chk("post rst out", out, 16'h0005);
    chk("post rst zcvn", {zero, carry, ovf, neg}, 4'b0000);
    consume("post rst");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
# alu_mc

Multi-cycle, parametrised ALU for the lab datapath. It generalises the single-cycle combinational ALU in three ways: a valid/ready handshake on input and output, an iterative shift-add multiplier that returns the full double-width product, and a full flag set (zero, carry, overflow, negative). It sits in the EX stage. The control unit stalls the pipeline while `in_ready` or `out_valid` is low.

## Interface
Parameters:
- `DSIZE`, default 16: operand and result width, ≥ 4.
- `SIGNED_CMP`, default 0: when 1, `COM` compares signed; when 0, unsigned.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operands and op presented.
- `in_ready` out 1: block can accept an operation.
- `a`, `b` in DSIZE: operands.
- `op` in 3: operation; codes are the shared `ADD/SUB/AND/XOR/SLL/SRL/COM/MUL` encodings.
- `out_valid` out 1: result and flags valid.
- `out_ready` in 1: consumer takes the result.
- `out` out DSIZE: result, or low product word for MUL.
- `out_hi` out DSIZE: high product word for MUL; 0 for all other ops.
- `zero`, `carry`, `ovf`, `neg` out 1: flags, valid with `out_valid`.
- `busy` out 1: a multiply is in progress.

## Operation
- FSM states: IDLE, MUL, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`, latch operands and op.
  - MUL goes to MUL with the iteration count cleared.
  - Every other op computes its result, registers it and goes to DONE.
- MUL state:
  - One multiplier bit per cycle, DSIZE iterations, unsigned.
  - `busy`=1 and `in_ready`=0.
  - After the last iteration, go to DONE.
- DONE:
  - `out_valid`=1; the result and flags are held stable until `out_ready`.
  - `in_ready` = `out_ready`, so a new op can be accepted in the same cycle the result is consumed (back-to-back).
  - Without a new op, go to IDLE.
- Arithmetic:
  - ADD: `out`=(a+b) mod 2^DSIZE; `carry`=bit DSIZE of the sum; `ovf`=signed overflow.
  - SUB: `out`=a−b; `carry`=borrow (a<b unsigned); `ovf`=signed overflow.
  - AND and XOR: bitwise.
  - SLL and SRL: logical shifts by the full unsigned value of `b`. Shift amounts ≥ DSIZE give 0.
  - COM: `out`={0…, a≤b}, using signed or unsigned comparison per `SIGNED_CMP`.
  - MUL: {`out_hi`,`out`} = a*b, 2·DSIZE bits.
- Flags:
  - `zero`: all result bits zero; for MUL the whole 2·DSIZE product.
  - `neg`: MSB of `out`, or MSB of `out_hi` for MUL.
  - `carry` and `ovf` are 0 for ops other than ADD and SUB.
- All 8 op codes are defined, so there is no default branch. Results are registered, so there are no latches.

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `busy`=0, `out`=`out_hi`=0, all flags 0.
- Latency, accept edge to `out_valid` high:
  - Non-MUL ops: 1 cycle.
  - MUL: DSIZE+1 cycles (17 at DSIZE=16).
- Throughput: 1 op/cycle for non-MUL ops when `out_ready` is held high.
- Handshake: transfers occur only on `valid && ready` at a rising edge. Inputs are ignored while `in_ready`=0.
- Reset asserted mid-multiply: the multiply is aborted, all outputs take their reset values immediately, and the partial product is discarded.
- `out_ready` high in IDLE or MUL has no effect.

## Structure
- Shared package `alu_pkg`:
  - op encodings;
  - FSM state enum;
  - `SHW = $clog2(DSIZE)` helper function.
- Sub-module `seq_mul`, a shift-add multiplier:
  - ports `start`, `a`, `b`, `done`, `prod[2*DSIZE-1:0]`;
  - same `clk`/`rst_n`;
  - instantiated once;
  - owns the iteration counter.
- The top level holds the FSM, the single-cycle datapath, the output registers and the flag logic.

## Test plan
All values at DSIZE=16.
- **ADD overflow**: ADD 0x7FFF + 0x0001 → `out`=0x8000, `ovf`=1, `neg`=1, `carry`=0, `zero`=0; `out_valid` 1 cycle after accept.
- **SUB borrow and zero**:
  - SUB 0x0003 − 0x0005 → `out`=0xFFFE, `carry`=1, `ovf`=0.
  - SUB 0x0005 − 0x0005 → `out`=0, `zero`=1.
- **MUL full product**: MUL 0xFFFF * 0xFFFF → `out_hi`=0xFFFE, `out`=0x0001.
  - `out_valid` exactly 17 cycles after accept.
  - `busy`=1 and `in_ready`=0 throughout.
- **Shifts and compare**:
  - SLL 0x0001 by 20 → 0.
  - SRL 0x8000 by 15 → 0x0001.
  - COM 0xFFFF ≤ 0x0001 → 0 with `SIGNED_CMP`=0, 1 with `SIGNED_CMP`=1.
- **Backpressure**: hold `out_ready` low for 5 cycles; result and flags stay stable. Then assert `out_ready` together with `in_valid` for XOR 0x00FF ^ 0x0F0F → accepted that cycle; `out`=0x0FF0 on the next cycle.
- **Reset mid-multiply**: pulse `rst_n` low during the 8th MUL cycle → outputs take reset values asynchronously. After release, ADD 2+3 → `out`=5 after 1 cycle.
